// File: rtl/region_decoder.sv
// Programmable address-region decoder: a table of base/width/wait entries feeds a
// bus-cycle FSM that produces a registered chip select plus a DTACK or BERR handshake.
module region_match #(
  parameter int AW = 24
) (
  input  logic          en,
  input  logic [AW-1:0] base,
  input  logic [4:0]    width,
  input  logic [AW-1:0] addr,
  output logic          match
);
  logic [AW-1:0] mask;

  // A width at or beyond the address width ignores every bit, so the entry matches everything.
  always_comb begin
    if (int'(width) >= AW) mask = '0;
    else                   mask = {AW{1'b1}} << width;
    match = en && (((addr ^ base) & mask) == '0);
  end
endmodule

module region_decoder #(
  parameter int REGIONS     = 24,
  parameter int AW          = 24,
  parameter int WS_W        = 4,
  parameter int BERR_CYCLES = 64,
  localparam int IW         = (REGIONS > 1) ? $clog2(REGIONS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [AW-1:0]      cfg_base,
  input  logic [4:0]         cfg_width,
  input  logic [WS_W-1:0]    cfg_wait,
  input  logic               cfg_en,
  input  logic [AW-1:0]      cpu_a,
  input  logic               cpu_as_n,
  output logic [REGIONS-1:0] cs,
  output logic [IW-1:0]      hit_idx,
  output logic               dtack_n,
  output logic               berr_n,
  output logic               busy
);
  localparam int WS_MAX  = (1 << WS_W) - 1;
  localparam int CNT_MAX = (WS_MAX > BERR_CYCLES) ? WS_MAX : BERR_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   base;
    logic [4:0]      width;
    logic [WS_W-1:0] ws;
  } entry_t;

  typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, MISS, ERR} state_t;

  entry_t             tbl [REGIONS];
  state_t             state, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [REGIONS-1:0] cs_d, match, hit_oh;
  logic [IW-1:0]      hit_d, hit_sel;
  logic [WS_W-1:0]    hit_ws;
  logic               hit_any, dtack_d, berr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REGIONS; i++) tbl[i] <= '0;
    end else if (cfg_we && (int'(cfg_idx) < REGIONS)) begin
      tbl[cfg_idx] <= '{en: cfg_en, base: cfg_base, width: cfg_width, ws: cfg_wait};
    end
  end

  for (genvar g = 0; g < REGIONS; g++) begin : g_match
    region_match #(.AW(AW)) u_match (
      .en    (tbl[g].en),
      .base  (tbl[g].base),
      .width (tbl[g].width),
      .addr  (a_q),
      .match (match[g])
    );
  end

  // Lowest matching index wins; hit_oh is one-hot by construction.
  always_comb begin
    hit_any = 1'b0;
    hit_oh  = '0;
    hit_sel = '0;
    hit_ws  = '0;
    for (int i = 0; i < REGIONS; i++) begin
      if (match[i] && !hit_any) begin
        hit_any   = 1'b1;
        hit_oh[i] = 1'b1;
        hit_sel   = IW'(i);
        hit_ws    = tbl[i].ws;
      end
    end
  end

  always_comb begin
    state_d = state;
    a_d     = a_q;
    cs_d    = cs;
    hit_d   = hit_idx;
    cnt_d   = cnt;
    dtack_d = dtack_n;
    berr_d  = berr_n;
    case (state)
      IDLE: if (!cpu_as_n) begin
        a_d     = cpu_a;
        state_d = DECODE;
      end
      DECODE: begin
        if (cpu_as_n) begin
          state_d = IDLE;
          cs_d    = '0;
        end else if (hit_any) begin
          cs_d    = hit_oh;
          hit_d   = hit_sel;
          cnt_d   = CW'(hit_ws);
          state_d = (hit_ws == '0) ? ACK : WAIT;
        end else begin
          cs_d    = '0;
          cnt_d   = CW'(BERR_CYCLES - 1);
          state_d = MISS;
        end
      end
      WAIT: begin
        if (cpu_as_n) begin
          state_d = IDLE;
          cs_d    = '0;
        end else begin
          if (cnt == CW'(1)) state_d = ACK;
          if (cnt != '0)     cnt_d   = cnt - CW'(1);
        end
      end
      ACK: begin
        if (cpu_as_n) begin
          state_d = IDLE;
          cs_d    = '0;
          dtack_d = 1'b1;
        end else begin
          dtack_d = 1'b0;
        end
      end
      MISS: begin
        if (cpu_as_n) begin
          state_d = IDLE;
          cs_d    = '0;
        end else if (cnt == '0) begin
          state_d = ERR;
          berr_d  = 1'b0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ERR: if (cpu_as_n) begin
        state_d = IDLE;
        berr_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      a_q     <= '0;
      cs      <= '0;
      hit_idx <= '0;
      cnt     <= '0;
      dtack_n <= 1'b1;
      berr_n  <= 1'b1;
    end else begin
      state   <= state_d;
      a_q     <= a_d;
      cs      <= cs_d;
      hit_idx <= hit_d;
      cnt     <= cnt_d;
      dtack_n <= dtack_d;
      berr_n  <= berr_d;
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: doc/region_decoder.md
REGION_DECODER -- requirements
Module: region_decoder

Interface
REQ-001 SHALL have parameter REGIONS, default 24: number of decode table entries (1..32).
REQ-002 SHALL have parameter AW, default 24: CPU address width.
REQ-003 SHALL have parameter WS_W, default 4: wait-state field width.
REQ-004 SHALL have parameter BERR_CYCLES, default 64: unmatched-cycle timeout in clocks (>=2).
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port cfg_we, input, 1: table write strobe.
REQ-008 SHALL have port cfg_idx, input, clog2(REGIONS): entry index.
REQ-009 SHALL have port cfg_base, input, AW: entry base address.
REQ-010 SHALL have port cfg_width, input, 5: count of low address bits ignored in compare.
REQ-011 SHALL have port cfg_wait, input, WS_W: wait states before acknowledge.
REQ-012 SHALL have port cfg_en, input, 1: entry enable.
REQ-013 SHALL have port cpu_a, input, AW: CPU address.
REQ-014 SHALL have port cpu_as_n, input, 1: address strobe, active-low.
REQ-015 SHALL have port cs, output, REGIONS: registered one-hot chip selects.
REQ-016 SHALL have port hit_idx, output, clog2(REGIONS): index of the selected entry.
REQ-017 SHALL have port dtack_n, output, 1: data acknowledge, active-low.
REQ-018 SHALL have port berr_n, output, 1: bus error, active-low.
REQ-019 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-020 SHALL perform a table write on a rising edge with cfg_we=1; the write takes effect from the next cycle, and a cfg_idx >= REGIONS SHALL be ignored.
REQ-021 SHALL declare entry i matched when en_i=1 and (A >> width_i) == (base_i >> width_i); a width_i >= AW SHALL match every address.
REQ-022 SHALL give priority to the lowest matching index; cs SHALL never have more than one bit set.
REQ-023 SHALL implement FSM states IDLE, DECODE, WAIT, ACK, MISS, ERR.
REQ-024 In IDLE, cpu_as_n sampled 0 at edge E0 SHALL latch cpu_a into A and move the FSM to DECODE.
REQ-025 In DECODE at edge E1, a match SHALL set cs[hit], set hit_idx=hit, and load the counter with wait_hit; the FSM SHALL go to ACK if wait_hit=0, else to WAIT.
REQ-026 In DECODE at edge E1, no match SHALL clear cs, load the counter with BERR_CYCLES-1, and move the FSM to MISS.
REQ-027 WAIT SHALL decrement the counter each cycle and go to ACK on the edge where the counter equals 1; dtack_n SHALL fall at edge E2+wait.
REQ-028 ACK SHALL drive dtack_n=0 and hold cs until cpu_as_n is sampled 1, then go to IDLE with cs=0 and dtack_n=1 on that same edge.
REQ-029 MISS SHALL decrement the counter and go to ERR on the edge where it equals 0; berr_n SHALL fall at edge E1+BERR_CYCLES.
REQ-030 ERR SHALL hold berr_n=0 until cpu_as_n is sampled 1, then go to IDLE with berr_n=1.
REQ-031 cpu_as_n sampled 1 in DECODE, WAIT or MISS (abort) SHALL return the FSM to IDLE on that edge with cs cleared and no dtack_n or berr_n pulse.
REQ-032 The match decision SHALL use table contents as they stand at E1; table writes made later in the cycle SHALL NOT change cs, hit_idx or the wait count of the active cycle.
REQ-033 A new cycle SHALL require one IDLE cycle; cpu_as_n held low across the return to IDLE SHALL be treated as a new strobe.
REQ-034 The counter SHALL be wide enough for max(2^WS_W-1, BERR_CYCLES) and SHALL NOT wrap.

Reset
REQ-035 reset_n=0 SHALL immediately force FSM=IDLE, cs=0, hit_idx=0, dtack_n=1, berr_n=1, busy=0, and clear every table entry's enable, including during an active cycle.
REQ-036 After reset is released, the table SHALL be empty, so every bus cycle ends in ERR until entries are written.

Verification
REQ-037 Write entry0 with base 0x000000, width 19, wait 0; drive A=0x012345 with AS_n low -> cs=0x000001 after E1, dtack_n=0 after E2, both released the cycle after AS_n rises.
REQ-038 Write entry3 with base 0x080000, width 15, wait 3; drive A=0x087FFE -> cs[3]=1, hit_idx=3, dtack_n low after E5; A=0x088000 -> no match, berr_n low after E1+64.
REQ-039 Write entry2 with base 0x400000, width 1, wait 0 and entry5 with base 0x400000, width 11, wait 0; drive A=0x400001 -> only cs[2]=1.
REQ-040 With entry3 at wait 3, raise AS_n in WAIT -> IDLE on that edge, dtack_n never falls, and the next strobe decodes normally.
REQ-041 Assert reset_n low during ACK -> dtack_n=1 and cs=0 without waiting for a clock edge; the next strobe after release produces berr_n after E1+64.
REQ-042 Rewrite entry3 to disabled during WAIT -> the current cycle still acknowledges; the next cycle to the same address gets berr_n.
